// File: rtl/matrix_preload_engine.sv
// matrix_preload_engine: writes N_MAT dim x dim pattern matrices into a shared
// single-port RAM over a ready/valid port, one element per accepted cycle.
module matrix_preload_engine #(
  parameter int DATA_W    = 9,
  parameter int DIM_MAX   = 5,
  parameter int N_MAT     = 2,
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0,
  localparam int DIM_W    = $clog2(DIM_MAX + 1),
  localparam int MAT_W    = (N_MAT > 1) ? $clog2(N_MAT) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        mode,
  input  logic [DIM_W-1:0]  dim,
  input  logic [DATA_W-1:0] seed,
  input  logic              wr_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [MAT_W-1:0]  wr_mat,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [1:0] MODE_RAMP  = 2'd0;
  localparam logic [1:0] MODE_FILL  = 2'd1;
  localparam logic [1:0] MODE_IDENT = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [DIM_W-1:0]  dim_q, dim_d;
  logic [DATA_W-1:0] seed_q, seed_d;
  logic [MAT_W-1:0]  m_q, m_d;
  logic [DIM_W-1:0]  r_q, r_d;
  logic [DIM_W-1:0]  c_q, c_d;
  logic [DATA_W-1:0] idx_q, idx_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [MAT_W-1:0]  wr_mat_q, wr_mat_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              dim_ok_s;
  logic [DIM_W-1:0]  dim_last_s;
  logic              accept_s;
  logic              last_s;

  function automatic logic [ADDR_W-1:0] elem_addr(input logic [MAT_W-1:0] m,
                                                   input logic [DIM_W-1:0] r,
                                                   input logic [DIM_W-1:0] c);
    logic [31:0] a;
    a = 32'(BASE_ADDR) + (32'(m) * 32'(DIM_MAX * DIM_MAX))
        + (32'(r) * 32'(DIM_MAX)) + 32'(c);
    return a[ADDR_W-1:0];
  endfunction

  // idx is the running element count, which equals m*dim*dim + r*dim + c
  function automatic logic [DATA_W-1:0] elem_data(input logic [1:0]        md,
                                                   input logic [DATA_W-1:0] sd,
                                                   input logic [DATA_W-1:0] idx,
                                                   input logic              diag);
    logic [DATA_W-1:0] v;
    case (md)
      MODE_RAMP:  v = sd + idx;
      MODE_FILL:  v = sd;
      MODE_IDENT: v = diag ? sd : {DATA_W{1'b0}};
      default:    v = {DATA_W{1'b0}};
    endcase
    return v;
  endfunction

  assign dim_ok_s   = (dim != {DIM_W{1'b0}}) && (dim <= DIM_W'(DIM_MAX));
  assign dim_last_s = dim_q - DIM_W'(1'b1);
  assign accept_s   = wr_en_q && wr_ready;
  assign last_s     = (m_q == MAT_W'(N_MAT - 1)) && (r_q == dim_last_s) && (c_q == dim_last_s);

  // Next-state, counter and registered-output computation
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    dim_d     = dim_q;
    seed_d    = seed_q;
    m_d       = m_q;
    r_d       = r_q;
    c_d       = c_q;
    idx_d     = idx_q;
    wr_en_d   = wr_en_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_mat_d  = wr_mat_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = err_q;
    case (state_q)
      S_IDLE: begin
        if (start && dim_ok_s) begin
          mode_d    = mode;
          dim_d     = dim;
          seed_d    = seed;
          m_d       = {MAT_W{1'b0}};
          r_d       = {DIM_W{1'b0}};
          c_d       = {DIM_W{1'b0}};
          idx_d     = {DATA_W{1'b0}};
          err_d     = 1'b0;
          wr_en_d   = 1'b1;
          busy_d    = 1'b1;
          wr_addr_d = elem_addr({MAT_W{1'b0}}, {DIM_W{1'b0}}, {DIM_W{1'b0}});
          wr_data_d = elem_data(mode, seed, {DATA_W{1'b0}}, 1'b1);
          wr_mat_d  = {MAT_W{1'b0}};
          state_d   = S_WRITE;
        end else if (start) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WRITE: begin
        if (abort) begin
          wr_en_d = 1'b0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (accept_s && last_s) begin
          wr_en_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else if (accept_s) begin
          if (c_q == dim_last_s) begin
            c_d = {DIM_W{1'b0}};
            if (r_q == dim_last_s) begin
              r_d = {DIM_W{1'b0}};
              m_d = m_q + MAT_W'(1'b1);
            end else begin
              r_d = r_q + DIM_W'(1'b1);
            end
          end else begin
            c_d = c_q + DIM_W'(1'b1);
          end
          idx_d     = idx_q + DATA_W'(1'b1);
          wr_addr_d = elem_addr(m_d, r_d, c_d);
          wr_data_d = elem_data(mode_q, seed_q, idx_d, r_d == c_d);
          wr_mat_d  = m_d;
        end else begin
          state_d = S_WRITE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, latched run parameters and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      mode_q    <= 2'd0;
      dim_q     <= {DIM_W{1'b0}};
      seed_q    <= {DATA_W{1'b0}};
      m_q       <= {MAT_W{1'b0}};
      r_q       <= {DIM_W{1'b0}};
      c_q       <= {DIM_W{1'b0}};
      idx_q     <= {DATA_W{1'b0}};
      wr_en_q   <= 1'b0;
      wr_addr_q <= {ADDR_W{1'b0}};
      wr_data_q <= {DATA_W{1'b0}};
      wr_mat_q  <= {MAT_W{1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      dim_q     <= dim_d;
      seed_q    <= seed_d;
      m_q       <= m_d;
      r_q       <= r_d;
      c_q       <= c_d;
      idx_q     <= idx_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_mat_q  <= wr_mat_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign wr_mat  = wr_mat_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule

// File: tb/tb_matrix_preload_engine.sv
// Directed bench for matrix_preload_engine: a scoreboard queue of expected
// writes is filled per run and drained as the DUT offers each element.
module tb_matrix_preload_engine;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [2:0] dim = 3'd0;
  logic [8:0] seed = 9'd0;
  logic       wr_ready = 1'b0;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [8:0] wr_data;
  logic [0:0] wr_mat;
  logic       busy;
  logic       done;
  logic       err;

  typedef struct packed {
    logic [7:0] addr;
    logic [8:0] data;
    logic       mat;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int acc_cnt = 0;
  int done_cnt = 0;

  matrix_preload_engine dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
    .dim(dim), .seed(seed), .wr_ready(wr_ready), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_mat(wr_mat), .busy(busy),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Independent model of the element sequence for one run
  task automatic push_run(input logic [1:0] md, input int dm, input logic [8:0] sd);
    exp_t e;
    for (int m = 0; m < 2; m++) begin
      for (int r = 0; r < dm; r++) begin
        for (int c = 0; c < dm; c++) begin
          e.addr = 8'(m * 25 + r * 5 + c);
          e.mat  = 1'(m);
          case (md)
            2'd0:    e.data = 9'(int'(sd) + m * dm * dm + r * dm + c);
            2'd1:    e.data = sd;
            2'd2:    e.data = (r == c) ? sd : 9'd0;
            default: e.data = 9'd0;
          endcase
          sb.push_back(e);
        end
      end
    end
  endtask

  task automatic check_bus();
    if (done) done_cnt++;
    if (wr_en) begin
      if (sb.size() == 0) begin
        chk("unexpected_write", 32'(wr_en), 32'd0);
      end else begin
        chk("wr_addr", 32'(wr_addr), 32'(sb[0].addr));
        chk("wr_data", 32'(wr_data), 32'(sb[0].data));
        chk("wr_mat", 32'(wr_mat), 32'(sb[0].mat));
        chk("busy_in_write", 32'(busy), 32'd1);
        if (wr_ready) begin
          void'(sb.pop_front());
          acc_cnt++;
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_bus();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_wr_en"}, 32'(wr_en), 32'd0);
    chk({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
    chk({tag, "_wr_data"}, 32'(wr_data), 32'd0);
    chk({tag, "_wr_mat"}, 32'(wr_mat), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
  endtask

  // One start-to-done run; poke>0 pulses start (with altered inputs) at that cycle
  task automatic do_run(input logic [1:0] md, input int dm, input logic [8:0] sd,
                        input bit toggle, input int poke, input int exp_cycles,
                        input bit exp_err);
    int cycles;
    acc_cnt  = 0;
    done_cnt = 0;
    mode     = md;
    dim      = 3'(dm);
    seed     = sd;
    wr_ready = 1'b1;
    start    = 1'b1;
    tick();
    start  = 1'b0;
    cycles = 1;
    forever begin
      wr_ready = toggle ? cycles[0] : 1'b1;
      start    = (cycles == poke);
      if (start) begin
        mode = 2'd1;
        dim  = 3'd5;
        seed = 9'h000;
      end
      if (done || cycles >= 400) break;
      tick();
      cycles++;
    end
    start    = 1'b0;
    wr_ready = 1'b1;
    chk("done_latency", 32'(cycles), 32'(exp_cycles));
    chk("err_at_done", 32'(err), 32'(exp_err));
    chk("wr_en_at_done", 32'(wr_en), 32'd0);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    chk("accepted_writes", 32'(acc_cnt), exp_err ? 32'd0 : 32'(2 * dm * dm));
    tick();
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("busy_after_done", 32'(busy), 32'd0);
    repeat (3) tick();
    chk("done_pulse_count", 32'(done_cnt), 32'd1);
  endtask

  initial begin
    #12;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    push_run(2'd0, 5, 9'd1);
    do_run(2'd0, 5, 9'd1, 1'b0, 0, 51, 1'b0);

    push_run(2'd2, 3, 9'd7);
    do_run(2'd2, 3, 9'd7, 1'b0, 0, 19, 1'b0);

    push_run(2'd1, 5, 9'h1FF);
    do_run(2'd1, 5, 9'h1FF, 1'b1, 0, 100, 1'b0);

    do_run(2'd0, 0, 9'd5, 1'b0, 0, 1, 1'b1);
    do_run(2'd0, 6, 9'd5, 1'b0, 0, 1, 1'b1);

    push_run(2'd3, 4, 9'd3);
    do_run(2'd3, 4, 9'd3, 1'b0, 0, 33, 1'b0);

    // Abort after ten accepted writes, stalling the eleventh
    begin
      int g;
      push_run(2'd0, 5, 9'd3);
      acc_cnt  = 0;
      done_cnt = 0;
      mode     = 2'd0;
      dim      = 3'd5;
      seed     = 9'd3;
      wr_ready = 1'b1;
      start    = 1'b1;
      tick();
      start = 1'b0;
      g = 0;
      while (acc_cnt < 10 && g < 100) begin
        tick();
        g++;
      end
      abort    = 1'b1;
      wr_ready = 1'b0;
      tick();
      abort    = 1'b0;
      wr_ready = 1'b1;
      chk("abort_wr_en", 32'(wr_en), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_accepted", 32'(acc_cnt), 32'd10);
      sb.delete();
      repeat (5) tick();
      chk("abort_no_done", 32'(done_cnt), 32'd0);
    end

    push_run(2'd0, 5, 9'd3);
    do_run(2'd0, 5, 9'd3, 1'b0, 0, 51, 1'b0);

    // Reset in the middle of a run
    push_run(2'd1, 4, 9'h0AA);
    acc_cnt  = 0;
    mode     = 2'd1;
    dim      = 3'd4;
    seed     = 9'h0AA;
    wr_ready = 1'b1;
    start    = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    chk("pre_reset_busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    sb.delete();
    done_cnt = 0;
    tick();
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("reset_no_done", 32'(done_cnt), 32'd0);
    chk("reset_idle_wr_en", 32'(wr_en), 32'd0);

    push_run(2'd0, 2, 9'd100);
    do_run(2'd0, 2, 9'd100, 1'b0, 3, 9, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
